// File: rtl/switch_pkg.sv
// Shared types and constants for the switch debounce/toggle bank.
// Latency: none (declarations only). Backpressure: none.
package switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } sw_state_t;

    localparam int EDGE_RELEASE = 0;
    localparam int EDGE_PRESS   = 1;

    // Defaults sized for a 25 MHz board clock: 10 ms debounce, 1 s long press.
    localparam int DEF_DEBOUNCE_LIMIT = 250000;
    localparam int DEF_CNT_W          = 18;
    localparam int DEF_LONG_LIMIT     = 25000000;
    localparam int DEF_LONG_W         = 25;

endpackage

// File: rtl/switch_channel.sv
// One switch: 2-FF sync, debounce, edge detect, IDLE/HELD/LONG FSM, toggle bit.
// Latency: raw edge -> o_Stable after DEBOUNCE_LIMIT+2 clocks, o_Event/o_Toggle one clock later.
// Backpressure: none; long press exists only with SWITCH_LONG_PRESS_EN defined.
module switch_channel
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int EDGE_SEL       = EDGE_RELEASE,
    parameter int PRESS_LEVEL    = 1,
    parameter int LONG_LIMIT     = DEF_LONG_LIMIT,
    parameter int LONG_W         = DEF_LONG_W
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    input  logic i_Clear,
    output logic o_Stable,
    output logic o_Event,
    output logic o_Toggle,
    output logic o_Long_Press
);

    localparam logic             PRESS_LVL = PRESS_LEVEL[0];
    localparam logic             ON_PRESS  = (EDGE_SEL == EDGE_PRESS);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_LIMIT - 1);

    if ((DEBOUNCE_LIMIT < 2) || ((DEBOUNCE_LIMIT >> CNT_W) != 0) ||
        (LONG_LIMIT < 1) || ((LONG_LIMIT >> LONG_W) != 0)) begin : g_bad_param
        $error("switch_channel: limit does not fit its counter width");
    end

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] db_cnt;
    logic             prev;
    logic             edge_hit;
    logic             long_enter;
    sw_state_t        state;
    sw_state_t        state_nxt;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            db_cnt    <= '0;
            o_Stable  <= 1'b0;
            prev      <= 1'b0;
            o_Event   <= 1'b0;
            o_Toggle  <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            sync_meta <= (i_Switch == PRESS_LVL);
            sync      <= sync_meta;
            if (sync == o_Stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                o_Stable <= sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
            prev    <= o_Stable;
            o_Event <= edge_hit;
            // Clear and long-press entry both override a coincident toggle flip.
            if (i_Clear || long_enter) begin
                o_Toggle <= 1'b0;
            end else if (edge_hit) begin
                o_Toggle <= ~o_Toggle;
            end
            state <= state_nxt;
        end
    end

    // A release that ends a long press is swallowed so the LED stays cleared.
    assign edge_hit = ON_PRESS ? (o_Stable & ~prev)
                               : (~o_Stable & prev & (state != ST_LONG));

`ifdef SWITCH_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_LIMIT - 1);
    logic [LONG_W-1:0] long_cnt;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || (state != ST_HELD)) begin
            long_cnt <= '0;
        end else if (long_cnt != LONG_LAST) begin
            long_cnt <= long_cnt + LONG_W'(1);
        end
    end

    assign long_enter = (state == ST_HELD) && o_Stable && (long_cnt == LONG_LAST);
`else
    assign long_enter = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (o_Stable) state_nxt = ST_HELD;
            ST_HELD: begin
                if (!o_Stable)       state_nxt = ST_IDLE;
                else if (long_enter) state_nxt = ST_LONG;
            end
            ST_LONG: if (!o_Stable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_Long_Press = long_enter;

endmodule

// File: rtl/switch_toggle_bank.sv
// NUM_CH independent debounced switch channels with event pulse and toggle bit each.
// Latency: raw edge -> o_Event/o_Toggle after DEBOUNCE_LIMIT+3 clocks; long press via SWITCH_LONG_PRESS_EN.
// Backpressure: none; every channel acts in the same cycle as its neighbours.
module switch_toggle_bank
    import switch_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int EDGE_SEL       = EDGE_RELEASE,
    parameter int PRESS_LEVEL    = 1,
    parameter int LONG_LIMIT     = DEF_LONG_LIMIT,
    parameter int LONG_W         = DEF_LONG_W
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic [NUM_CH-1:0] i_Clear,
    output logic [NUM_CH-1:0] o_Stable,
    output logic [NUM_CH-1:0] o_Event,
    output logic [NUM_CH-1:0] o_Toggle,
    output logic [NUM_CH-1:0] o_Long_Press
);

    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
        $error("switch_toggle_bank: NUM_CH must be 1..16");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        switch_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .CNT_W          (CNT_W),
            .EDGE_SEL       (EDGE_SEL),
            .PRESS_LEVEL    (PRESS_LEVEL),
            .LONG_LIMIT     (LONG_LIMIT),
            .LONG_W         (LONG_W)
        ) u_ch (
            .i_Clk        (i_Clk),
            .i_Rst_L      (i_Rst_L),
            .i_Switch     (i_Switch[i]),
            .i_Clear      (i_Clear[i]),
            .o_Stable     (o_Stable[i]),
            .o_Event      (o_Event[i]),
            .o_Toggle     (o_Toggle[i]),
            .o_Long_Press (o_Long_Press[i])
        );
    end

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Scoreboard bench: release-edge and press-edge banks share inputs; expected pulses are queued
// at stimulus time and popped by a negedge monitor whenever a bank raises o_Event or o_Long_Press.
`timescale 1ns/1ps
module tb_switch_toggle_bank;
    import switch_pkg::*;

    localparam int N = 4;

    typedef struct {
        int         cyc;
        logic [N-1:0] vec;
        logic [N-1:0] tog;
        bit         chk_tog;
    } exp_t;

    logic         i_Clk = 1'b0;
    logic         i_Rst_L;
    logic [N-1:0] sw;
    logic [N-1:0] clr;
    logic [N-1:0] stb0, ev0, tog0, lp0;
    logic [N-1:0] stb1, ev1, tog1, lp1;
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    bit           mon_en = 1'b0;
    exp_t         q [4][$];
    string        nm [4] = '{"event_rel", "event_press", "long_rel", "long_press"};

    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) cyc <= cyc + 1;

    switch_toggle_bank #(
        .NUM_CH(N), .DEBOUNCE_LIMIT(4), .CNT_W(3), .EDGE_SEL(EDGE_RELEASE),
        .PRESS_LEVEL(1), .LONG_LIMIT(16), .LONG_W(5)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(sw), .i_Clear(clr),
        .o_Stable(stb0), .o_Event(ev0), .o_Toggle(tog0), .o_Long_Press(lp0)
    );

    switch_toggle_bank #(
        .NUM_CH(N), .DEBOUNCE_LIMIT(4), .CNT_W(3), .EDGE_SEL(EDGE_PRESS),
        .PRESS_LEVEL(1), .LONG_LIMIT(16), .LONG_W(5)
    ) dut_p (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(sw), .i_Clear(clr),
        .o_Stable(stb1), .o_Event(ev1), .o_Toggle(tog1), .o_Long_Press(lp1)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // w: 0 release-bank event, 1 press-bank event, 2 release-bank long, 3 press-bank long
    function automatic void exp_out(input int w, input int c, input logic [N-1:0] v,
                                    input logic [N-1:0] t, input bit ct);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        e.tog = t;
        e.chk_tog = ct;
        q[w].push_back(e);
    endfunction

    always @(negedge i_Clk) begin
        logic [N-1:0] obs [4];
        exp_t e;
        obs[0] = ev0;
        obs[1] = ev1;
        obs[2] = lp0;
        obs[3] = lp1;
        if (mon_en) begin
            for (int w = 0; w < 4; w++) begin
                if (obs[w] !== '0) begin
                    if (q[w].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_%s: got %b, expected no pulse (cycle %0d)",
                                 nm[w], obs[w], cyc);
                    end else begin
                        e = q[w].pop_front();
                        check_int({nm[w], "_cycle"}, cyc, e.cyc);
                        check({nm[w], "_vec"}, obs[w], e.vec);
                        if (e.chk_tog)
                            check({nm[w], "_toggle"}, (w == 0) ? tog0 : tog1, e.tog);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        i_Rst_L = 1'b0;
        sw      = '0;
        clr     = '0;
        tick(3);
        mon_en = 1'b1;
        check("rst_stable", stb0 | stb1, '0);
        check("rst_event", ev0 | ev1, '0);
        check("rst_toggle", tog0 | tog1, '0);
        check("rst_long", lp0 | lp1, '0);
        i_Rst_L = 1'b1;
        tick(50);
        check("idle_stable", stb0 | stb1, '0);
        check("idle_toggle", tog0 | tog1, '0);

        // ch0 press/release twice: toggle 0->1->0
        k = cyc;
        sw[0] = 1'b1;
        exp_out(1, k + 7, 4'b0001, 4'b0001, 1'b1);
        tick(5);
        check("ch0_stable_before", stb0, 4'b0000);
        tick(1);
        check("ch0_stable_rise", stb0, 4'b0001);
        tick(4);
        sw[0] = 1'b0;
        exp_out(0, k + 17, 4'b0001, 4'b0001, 1'b1);
        tick(20);
        k = cyc;
        sw[0] = 1'b1;
        exp_out(1, k + 7, 4'b0001, 4'b0000, 1'b1);
        tick(10);
        sw[0] = 1'b0;
        exp_out(0, k + 17, 4'b0001, 4'b0000, 1'b1);
        tick(20);
        check("ch0_toggle_back", tog0, 4'b0000);

        // ch1 bounce: 3-high/1-low glitches are shorter than the limit
        repeat (7) begin
            sw[1] = 1'b1;
            tick(3);
            sw[1] = 1'b0;
            tick(1);
        end
        tick(2);
        check("ch1_bounce_stable", stb0 | stb1, 4'b0000);
        k = cyc;
        sw[1] = 1'b1;
        exp_out(1, k + 7, 4'b0010, 4'b0010, 1'b1);
        tick(8);
        check("ch1_stable_high", stb0, 4'b0010);
        sw[1] = 1'b0;
        exp_out(0, k + 15, 4'b0010, 4'b0010, 1'b1);
        tick(20);
        check("ch1_stable_low", stb0, 4'b0000);
        check("ch1_toggle", tog0, 4'b0010);

        // ch2+ch3 together, clear on ch3 overlapping its release event
        k = cyc;
        sw[3:2] = 2'b11;
        exp_out(1, k + 7, 4'b1100, 4'b1110, 1'b1);
        tick(10);
        sw[3:2] = 2'b00;
        tick(6);
        clr[3] = 1'b1;
        exp_out(0, k + 17, 4'b1100, 4'b0110, 1'b1);
        tick(2);
        clr[3] = 1'b0;
        tick(15);
        check("clear_toggle_rel", tog0, 4'b0110);
        check("clear_toggle_press", tog1, 4'b0110);

        // reset while ch0 is held: everything returns to 0, no long pulse, no event after
        k = cyc;
        sw[0] = 1'b1;
        exp_out(1, k + 7, 4'b0001, 4'b0111, 1'b1);
        tick(12);
        i_Rst_L = 1'b0;
        sw[0] = 1'b0;
        tick(2);
        check("midrst_stable", stb0 | stb1, 4'b0000);
        check("midrst_toggle", tog0 | tog1, 4'b0000);
        i_Rst_L = 1'b1;
        tick(30);
        check("post_rst_outputs", stb0 | stb1 | tog0 | tog1, 4'b0000);

`ifdef SWITCH_LONG_PRESS_EN
        // set toggle, then hold long enough for a long press
        k = cyc;
        sw[0] = 1'b1;
        exp_out(1, k + 7, 4'b0001, 4'b0001, 1'b1);
        tick(10);
        sw[0] = 1'b0;
        exp_out(0, k + 17, 4'b0001, 4'b0001, 1'b1);
        tick(20);
        k = cyc;
        sw[0] = 1'b1;
        exp_out(1, k + 7, 4'b0001, 4'b0000, 1'b1);
        exp_out(2, k + 22, 4'b0001, 4'b0000, 1'b0);
        exp_out(3, k + 22, 4'b0001, 4'b0000, 1'b0);
        tick(25);
        check("long_toggle_cleared", tog0, 4'b0000);
        tick(5);
        sw[0] = 1'b0;
        tick(20);
        check("long_release_toggle", tog0, 4'b0000);
        check("long_release_stable", stb0, 4'b0000);
`endif

        for (int w = 0; w < 4; w++)
            check_int({"pending_", nm[w]}, q[w].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
